// File: rtl/shift_seq_ctrl_pkg.sv
// Shared constants for the multi-cycle shift sequencer: widths, op codes, FSM state encodings.
package shift_seq_ctrl_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;
    localparam int AMT_W = 3;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate step by amt_i bits (1, 2 or 4); no state, zero latency.
module shift_step
    import shift_seq_ctrl_pkg::*;
(
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       op_i,
    input  logic [AMT_W-1:0] amt_i,
    output logic [WIDTH-1:0] data_o
);

    logic [2*WIDTH-1:0] dbl;

    always_comb begin
        // Rotate: shift a doubled copy and keep the upper half so MSBs wrap into the LSBs.
        dbl    = {data_i, data_i} << amt_i;
        data_o = data_i;
        case (op_i)
            OP_ROL:  data_o = dbl[2*WIDTH-1:WIDTH];
            OP_SLL:  data_o = data_i << amt_i;
            OP_SRA:  data_o = $signed(data_i) >>> amt_i;
            OP_SRL:  data_o = data_i >> amt_i;
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: done pulses ceil(cnt/2) + 1 cycles after start is accepted.
// Optional SHIFT_SEQ_FAST_EN adds 4-bit steps; start is only accepted in IDLE or DONE.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic [1:0]       op_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] out_o
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0] rem_q,   rem_d;
    logic [1:0]       op_q,    op_d;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] step_out;

    always_comb begin
`ifdef SHIFT_SEQ_FAST_EN
        if (rem_q >= 4'd4)      amt = 3'd4;
        else if (rem_q >= 4'd2) amt = 3'd2;
        else                    amt = 3'd1;
`else
        if (rem_q >= 4'd2) amt = 3'd2;
        else               amt = 3'd1;
`endif
    end

    shift_step u_step (
        .data_i (acc_q),
        .op_i   (op_q),
        .amt_i  (amt),
        .data_o (step_out)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    acc_d   = in_i;
                    rem_d   = cnt_i;
                    op_d    = op_i;
                    state_d = (cnt_i != '0) ? ST_SHIFT : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_d = step_out;
                rem_d = rem_q - {1'b0, amt};
                if (rem_q == {1'b0, amt}) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            op_q    <= OP_ROL;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    assign busy_o = (state_q == ST_SHIFT);
    assign done_o = (state_q == ST_DONE);
    assign out_o  = acc_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed vector table, corner sequences, random ops vs. arithmetic model.
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] in_i;
    logic [1:0]  op_i;
    logic [3:0]  cnt_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] out_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .start_i (start_i),
        .in_i    (in_i),
        .op_i    (op_i),
        .cnt_i   (cnt_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .out_o   (out_o)
    );

    typedef struct {
        logic [15:0] din;
        logic [1:0]  op;
        logic [3:0]  cnt;
        logic [15:0] exp_out;
        int          lat_def;
        int          lat_fast;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference result straight from the definition of each operation.
    function automatic logic [15:0] ref_shift(input logic [15:0] x, input logic [1:0] o, input int c);
        logic [31:0]        y;
        logic signed [15:0] s;
        y = {x, x};
        s = x;
        case (o)
            2'b00: begin y = y << (c % 16); return y[31:16]; end
            2'b01: return x << c;
            2'b10: return s >>> c;
            default: return x >> c;
        endcase
    endfunction

    function automatic int exp_lat(input int c);
`ifdef SHIFT_SEQ_FAST_EN
        return 1 + c / 4 + (c % 4) / 2 + c % 2;
`else
        return 1 + (c + 1) / 2;
`endif
    endfunction

    // Called at a negedge; issues start now and returns at the negedge where done is seen.
    task automatic run_op(input logic [15:0] d, input logic [1:0] o, input logic [3:0] c,
                          input int poke, output logic [15:0] got, output int lat,
                          output bit busy_ok);
        in_i = d; op_i = o; cnt_i = c; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        in_i = 16'($urandom); op_i = 2'($urandom); cnt_i = 4'($urandom);
        lat = 99;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (done_o) begin
                lat = k;
                if (busy_o) busy_ok = 1'b0;
                break;
            end
            if (!busy_o) busy_ok = 1'b0;
            start_i = (k == poke);
            @(negedge clk);
            start_i = 1'b0;
        end
        start_i = 1'b0;
        got = out_o;
    endtask

    initial begin
        logic [15:0] got;
        int          lat;
        int          elat;
        bit          bok;
        bit          seen;
        logic [15:0] rd;
        logic [1:0]  ro;
        logic [3:0]  rc;

        vecs[0] = '{16'h8001, 2'b00, 4'd4,  16'h0018, 3, 2};
        vecs[1] = '{16'h8000, 2'b10, 4'd15, 16'hFFFF, 9, 6};
        vecs[2] = '{16'h8000, 2'b11, 4'd15, 16'h0001, 9, 6};
        vecs[3] = '{16'h00FF, 2'b01, 4'd0,  16'h00FF, 1, 1};
        vecs[4] = '{16'h00FF, 2'b01, 4'd8,  16'hFF00, 5, 3};
        vecs[5] = '{16'h1234, 2'b11, 4'd1,  16'h091A, 2, 2};
        vecs[6] = '{16'h1234, 2'b00, 4'd7,  16'h1A09, 5, 4};
        vecs[7] = '{16'h7FF0, 2'b10, 4'd3,  16'h0FFE, 3, 3};

        rst_i = 1'b1; start_i = 1'b0; in_i = 16'hA5A5; op_i = 2'b01; cnt_i = 4'd5;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy_o), 0);
        chk("reset_done", 32'(done_o), 0);
        chk("reset_out",  32'(out_o),  0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("idle_no_done", 32'(done_o), 0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].din, vecs[i].op, vecs[i].cnt, 0, got, lat, bok);
            chk($sformatf("vec%0d_out", i), 32'(got), 32'(vecs[i].exp_out));
`ifdef SHIFT_SEQ_FAST_EN
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat_fast));
`else
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat_def));
`endif
            chk($sformatf("vec%0d_busy", i), 32'(bok), 1);
            @(negedge clk);
            chk($sformatf("vec%0d_pulse", i), 32'(done_o), 0);
        end

        // start pulsed mid-SHIFT must be ignored
        run_op(16'h8000, 2'b11, 4'd10, 2, got, lat, bok);
        chk("poke_out", 32'(got), 32'h0020);
        chk("poke_lat", 32'(lat), 32'(exp_lat(10)));

        // back-to-back: new start accepted in the DONE cycle
        run_op(16'h00FF, 2'b01, 4'd0, 0, got, lat, bok);
        chk("b2b_out", 32'(got), 32'h00FF);
        chk("b2b_lat", 32'(lat), 1);
        run_op(16'h8001, 2'b00, 4'd4, 0, got, lat, bok);
        chk("b2b2_out", 32'(got), 32'h0018);
        chk("b2b2_lat", 32'(lat), 32'(exp_lat(4)));
        @(negedge clk);

        // reset in the 3rd SHIFT cycle of a cnt=12 operation
        in_i = 16'h8000; op_i = 2'b10; cnt_i = 4'd12; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy_before", 32'(busy_o), 1);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_done", 32'(done_o), 0);
        chk("abort_out",  32'(out_o),  0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 0);

        for (int n = 0; n < 1000; n++) begin
            rd = 16'($urandom); ro = 2'($urandom); rc = 4'($urandom);
            run_op(rd, ro, rc, 0, got, lat, bok);
            elat = exp_lat(int'(rc));
            chk("rnd_out", 32'(got), 32'(ref_shift(rd, ro, int'(rc))));
            chk("rnd_lat", 32'(lat), 32'(elat));
            chk("rnd_busy", 32'(bok), 1);
            if ($urandom_range(1, 0) == 0) begin
                @(negedge clk);
                chk("rnd_pulse", 32'(done_o), 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
